// File: rtl/skinny_sbox_pkg.sv
// Shared constants and helpers for the masked SKINNY-128 8-bit S-box.
package skinny_sbox_pkg;

    // Number of Boolean shares for masking order d.
    function automatic int unsigned nshares(input int unsigned d);
        return d + 1;
    endfunction

    // Fresh random bits consumed by one DOM-indep AND gate.
    function automatic int unsigned rand_per_gate(input int unsigned d);
        return (d * (d + 1)) / 2;
    endfunction

    // Position of pair (i,j), i<j, in the per-gate randomness slice.
    function automatic int unsigned pair_index(input int unsigned n,
                                               input int unsigned i,
                                               input int unsigned j);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Bit permutation for iterations 1-3: y[k] = x[PERM[k]].
    localparam int unsigned PERM [8] = '{5, 3, 0, 4, 6, 7, 1, 2};

    // Bits swapped by the final iteration instead of the full permutation.
    localparam int unsigned SWAP_A = 1;
    localparam int unsigned SWAP_B = 2;

    // Linear part of one iteration applied to a single share:
    // XOR the nonlinear contributions into bits 4 and 0, then permute or swap.
    function automatic logic [7:0] lin_step(input logic [7:0] x,
                                            input logic       z4,
                                            input logic       z0,
                                            input logic       last);
        logic [7:0] t;
        logic [7:0] y;
        t    = x;
        t[4] = t[4] ^ z4;
        t[0] = t[0] ^ z0;
        y    = t;
        if (last) begin
            y[SWAP_A] = t[SWAP_B];
            y[SWAP_B] = t[SWAP_A];
        end else begin
            for (int unsigned k = 0; k < 8; k++) begin
                y[k] = t[PERM[k]];
            end
        end
        return y;
    endfunction

    // Unmasked S8 from the round description.
    function automatic logic [7:0] s8_calc(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int unsigned it = 0; it < 4; it++) begin
            x = lin_step(x, ~(x[7] | x[6]), ~(x[3] | x[2]), (it == 3));
        end
        return x;
    endfunction

    typedef logic [7:0] sbox_table_t [256];

    function automatic sbox_table_t build_s8_table();
        sbox_table_t t;
        for (int unsigned v = 0; v < 256; v++) begin
            t[v] = s8_calc(v[7:0]);
        end
        return t;
    endfunction

    localparam sbox_table_t S8_TABLE = build_s8_table();

endpackage

// File: rtl/skinny_sbox8_dom_np_and.sv
// First-order-and-up DOM-independent AND gate with registered terms.
module dom_indep_and
    import skinny_sbox_pkg::*;
#(
    parameter int unsigned d = 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [d:0]               a,
    input  logic [d:0]               b,
    input  logic [(d*(d+1))/2-1:0]   r,
    output logic [d:0]               z
);

    localparam int unsigned N = nshares(d);

    // terms[i][j] holds a[i]&b[j] (remasked when i!=j) for output share i.
    logic [N-1:0][N-1:0] terms;

    // Register every inner and cross term before any recombination.
    always_ff @(posedge clk) begin
        if (rst) begin
            terms <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (i == j) begin
                        terms[i][j] <= a[i] & b[i];
                    end else if (i < j) begin
                        terms[i][j] <= (a[i] & b[j]) ^ r[pair_index(N, i, j)];
                    end else begin
                        terms[i][j] <= (a[i] & b[j]) ^ r[pair_index(N, j, i)];
                    end
                end
            end
        end
    end

    // Compress registered terms per output share.
    always_comb begin
        z = '0;
        for (int unsigned i = 0; i < N; i++) begin
            z[i] = ^terms[i];
        end
    end

endmodule

// File: rtl/skinny_sbox8_table.sv
// Unmasked SKINNY-128 8-bit S-box lookup, purely combinational.
module skinny_sbox8_table
    import skinny_sbox_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    // Direct table lookup.
    always_comb begin
        y = S8_TABLE[x];
    end

endmodule

// File: rtl/skinny_sbox8_dom_np.sv
// Masked SKINNY-128 8-bit S-box, DOM-indep, one register stage per iteration.
module skinny_sbox8_dom_np
    import skinny_sbox_pkg::*;
#(
    parameter int unsigned d = 1
)
(
    input  logic                     clk,
    input  logic                     rst,
    output logic [8*(d+1)-1:0]       so,
    input  logic [8*(d+1)-1:0]       si,
    input  logic [4*d*(d+1)-1:0]     r
);

    localparam int unsigned N  = nshares(d);
    localparam int unsigned RB = rand_per_gate(d);

    // Gate g: operands ga[g]/gb[g] and registered result gz[g], one bit per share.
    logic [7:0][N-1:0] ga;
    logic [7:0][N-1:0] gb;
    logic [7:0][N-1:0] gz;

    // Running share state while walking the four iterations.
    logic [N-1:0][7:0] st;

    for (genvar g = 0; g < 8; g++) begin : g_and
        dom_indep_and #(.d(d)) u_and (
            .clk (clk),
            .rst (rst),
            .a   (ga[g]),
            .b   (gb[g]),
            .r   (r[g*RB +: RB]),
            .z   (gz[g])
        );
    end

    // Linear layer: each iteration feeds its gates from the state built so
    // far, then folds in the registered gate results. The chain is purely
    // combinational from si; only the AND terms are stored, so the result
    // settles one iteration per clock edge.
    always_comb begin
        ga = '0;
        gb = '0;
        st = si;
        for (int unsigned k = 0; k < 4; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                // NOR(a,b) = AND(~a,~b); negation flips share 0 only.
                ga[2*k][i]   = st[i][7] ^ (i == 0);
                gb[2*k][i]   = st[i][6] ^ (i == 0);
                ga[2*k+1][i] = st[i][3] ^ (i == 0);
                gb[2*k+1][i] = st[i][2] ^ (i == 0);
            end
            for (int unsigned i = 0; i < N; i++) begin
                st[i] = lin_step(st[i], gz[2*k][i], gz[2*k+1][i], (k == 3));
            end
        end
        so = st;
    end

endmodule

// File: tb/tb_skinny_sbox8_dom_np.sv
// Scoreboard bench for the masked SKINNY 8-bit S-box and its unmasked table.
module tb_skinny_sbox8_dom_np;

    localparam int unsigned D = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] so;
    logic [15:0] si;
    logic [7:0]  r;
    logic [7:0]  tx;
    logic [7:0]  ty;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    skinny_sbox8_dom_np #(.d(D)) dut (
        .clk (clk),
        .rst (rst),
        .so  (so),
        .si  (si),
        .r   (r)
    );

    skinny_sbox8_table u_tab (
        .x (tx),
        .y (ty)
    );

    // Independent reference: explicit bit concatenations per round.
    function automatic logic [7:0] model_s8(input logic [7:0] v);
        logic [7:0] x;
        x = v;
        for (int it = 0; it < 4; it++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            if (it < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
            else        x = {x[7:3], x[1], x[2], x[0]};
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // Drive shares {m, x^m}, queue the expectation, hold 4 edges, compare.
    task automatic apply(input string tag, input logic [7:0] x,
                         input logic [7:0] m, input logic [7:0] rr);
        logic [7:0] want;
        si = {m, x ^ m};
        r  = rr;
        exp_q.push_back(model_s8(x));
        repeat (4) @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 16'h0001, 16'h0000);
        end else begin
            want = exp_q.pop_front();
            check(tag, {8'h00, so[7:0] ^ so[15:8]}, {8'h00, want});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] masks [3];
        logic [7:0] rvals [2];
        masks = '{8'h00, 8'hFF, 8'hA5};
        rvals = '{8'h00, 8'hFF};

        rst = 1'b1;
        si  = '0;
        r   = '0;
        tx  = '0;
        repeat (2) @(posedge clk);
        #1;
        // All AND registers clear; zero shares pass through the linear layer as zero.
        check("reset_so", so, 16'h0000);
        rst = 1'b0;

        // Known table points, with latency from back-to-back application.
        apply("s8_00", 8'h00, 8'h3C, 8'h5A);
        check("s8_00_const", {8'h00, so[7:0] ^ so[15:8]}, 16'h0065);
        apply("s8_01_latency", 8'h01, 8'hC3, 8'h96);
        check("s8_01_const", {8'h00, so[7:0] ^ so[15:8]}, 16'h004C);

        // Mask and randomness independence.
        foreach (masks[mi]) begin
            foreach (rvals[ri]) begin
                apply("mask_indep", 8'h00, masks[mi], rvals[ri]);
            end
        end

        // Reset aborts an in-flight computation.
        si = {8'h77, 8'h12 ^ 8'h77};
        r  = 8'h3D;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply("reset_abort", 8'hFF, 8'h5E, 8'hC1);
        check("s8_ff_const", {8'h00, so[7:0] ^ so[15:8]}, 16'h00FF);

        // Exhaustive with random masks and randomness.
        for (int v = 0; v < 256; v++) begin
            apply("exhaustive", 8'(v), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        // Unmasked table against the round formula.
        for (int v = 0; v < 256; v++) begin
            tx = 8'(v);
            #1;
            check("table", {8'h00, ty}, {8'h00, model_s8(tx)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/skinny_sbox8_dom_np.md
Name: skinny_sbox8_dom_np

Overview:
- Masked SKINNY-128 8-bit S-box, first-order DOM-independent (d=1), non-pipelined.
- Takes d+1 Boolean shares of one byte plus fresh randomness and returns d+1 shares of S8(x).
- Used as the nonlinear layer of the side-channel-protected SKINNY-128-384+ datapath.
- Companion combinational table skinny_sbox8_table gives the unmasked S8, used as the golden model.

Parameters:
- d, 1, masking order; share count is d+1. d=1 is the only mandatory configuration; d>1 follows the generic DOM-indep rules below.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- so  out  8*(d+1)  output shares; share j is so[8j+7:8j]. XOR of all shares = S8(x).
- si  in  8*(d+1)  input shares; share j is si[8j+7:8j]. XOR of all shares = x.
- r  in  4*d*(d+1)  fresh randomness; 8 bits for d=1.

Behaviour:
- Unmasked S8 is 4 iterations of a round.
  - Round: x4 ^= NOR(x7,x6); x0 ^= NOR(x3,x2).
  - Iterations 1-3 then apply the bit permutation (y7..y0) = (x2,x1,x7,x6,x4,x0,x3,x5).
  - Iteration 4 applies only a swap of bits 1 and 2.
- Masked NOR(a,b) is AND(~a,~b). Negation inverts share 0 only.
- DOM-indep AND of shares ai, bi:
  - Inner terms ai&bi.
  - Cross terms ai&bj ^ r_ij for i<j, with r_ij shared between pair (i,j) and (j,i).
  - Inner and cross terms are all registered, then compressed by XOR per share.
- Gate numbering: iteration k (0..3) has gate 2k (the x4 update) and gate 2k+1 (the x0 update).
- Randomness: gate g uses the d(d+1)/2-bit slice r[g*d(d+1)/2 +: d(d+1)/2]. For d=1, gate g uses r[g].
- Linear XOR/permutation operations are share-wise and combinational.
- Non-pipelined: one register stage per iteration, so 4 register stages in total.
  - Each stage's unregistered linear share bits come combinationally from si through the earlier stages.
- Latency: si and r must be held stable for at least 4 rising edges.
  - so is valid from the 4th rising edge after si/r are applied, and stays valid while they are held.
- si or r changing mid-computation: so is undefined until 4 further edges with stable inputs.
- Reset: all AND-gate registers clear to 0 on a rising edge with rst=1.
  - so is not valid until 4 edges after rst deasserts with stable inputs.
  - Reset mid-computation aborts it. There is no valid/busy handshake.
- Correctness must hold for every mask value and every r value. so must never depend on recombined secrets within a single register.
- skinny_sbox8_table: purely combinational, 8-bit in / 8-bit out, S8(x), no clock.

Decomposition:
- Package skinny_sbox_pkg:
  - NSHARES = d+1 (as a function of d).
  - Random bits per gate, d(d+1)/2.
  - Permutation index constants.
  - The 256-entry S8 table used by skinny_sbox8_table.
- One sub-module dom_indep_and:
  - Parameter d.
  - Inputs: a shares, b shares, gate randomness, clk, rst.
  - Output: registered z shares.
- Instantiate it 8 times (2 per iteration).

Test Plan:
- Exhaustive: for x=0..255 with random mask m and random r, drive si={m, x^m}, hold 4 edges, check so[7:0]^so[15:8] == S8(x), e.g. 0x00->0x65, 0x01->0x4c, 0xFF->0xFF.
- Mask independence: x=0x00 with m in {0x00, 0xFF, 0xA5} and r in {0x00, 0xFF} -> recombined 0x65 in all cases.
- Latency: apply x=0x01 right after a valid 0x00 result; recombined output equals 0x4c at the 4th edge.
- Reset: assert rst one cycle mid-computation, release, hold si for x=0xFF for 4 edges -> 0xFF.
- Golden check: skinny_sbox8_table agrees with the round-iteration formula for all 256 inputs.
